// File: rtl/stonyman_pkg.sv
// ----------------------------------------------------------------------------
// stonyman_pkg
//   Shared types and constants for the Stonyman image sensor scan controller:
//   FSM state encoding, sensor register addresses, pulse line select encoding
//   and the helper that expands one step of a sensor register WRITE sequence.
// ----------------------------------------------------------------------------
package stonyman_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE,
    ST_CFG,
    ST_ROW_SEL,
    ST_COL_RST,
    ST_SETTLE,
    ST_CAPTURE,
    ST_WAIT_DONE,
    ST_COL_INC,
    ST_ROW_NEXT,
    ST_DONE
  } state_e;

  // Sensor register addresses (pointer positions after a resp pulse).
  localparam logic [6:0] ADDR_COLSEL = 7'd0;
  localparam logic [6:0] ADDR_ROWSEL = 7'd1;
  localparam logic [6:0] ADDR_VREF   = 7'd4;
  localparam logic [6:0] ADDR_CONFIG = 7'd5;
  localparam logic [6:0] ADDR_NBIAS  = 7'd6;
  localparam logic [6:0] ADDR_AOBIAS = 7'd7;

  typedef enum logic [1:0] {
    LINE_RESP,
    LINE_INCP,
    LINE_RESV,
    LINE_INCV
  } line_e;

  // One request to the pulse generator: which line and how many pulses.
  typedef struct packed {
    line_e      line;
    logic [6:0] count;
  } pulse_req_t;

  // A WRITE(addr, val) is four requests: resp x1, incp x addr, resv x1, incv x val.
  function automatic pulse_req_t write_step(input logic [1:0] phase,
                                            input logic [6:0] addr,
                                            input logic [6:0] val);
    pulse_req_t r;
    case (phase)
      2'd0:    begin r.line = LINE_RESP; r.count = 7'd1; end
      2'd1:    begin r.line = LINE_INCP; r.count = addr; end
      2'd2:    begin r.line = LINE_RESV; r.count = 7'd1; end
      default: begin r.line = LINE_INCV; r.count = val;  end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stonyman_if.sv
// ----------------------------------------------------------------------------
// stonyman_if
//   Frame request / ADC handshake / sensor line bundle of the scan controller.
//   master : the controller (drives capture start, status, pixel and lines)
//   slave  : the environment (frame requests, ADC done, sensor)
// ----------------------------------------------------------------------------
interface stonyman_if;
  logic       frame_start;
  logic       adc_capture_done;
  logic       adc_capture_start;
  logic       frame_busy;
  logic       frame_done;
  logic [6:0] pixel_row;
  logic [6:0] pixel_col;
  logic       resp;
  logic       incp;
  logic       resv;
  logic       incv;

  modport master (
    input  frame_start, adc_capture_done,
    output adc_capture_start, frame_busy, frame_done, pixel_row, pixel_col,
           resp, incp, resv, incv
  );

  modport slave (
    output frame_start, adc_capture_done,
    input  adc_capture_start, frame_busy, frame_done, pixel_row, pixel_col,
           resp, incp, resv, incv
  );
endinterface

// File: rtl/stonyman_pulse_gen.sv
// ----------------------------------------------------------------------------
// stonyman_pulse_gen
//   Emits `count` pulses (PULSE_CYCLES high, PULSE_CYCLES low) on one sensor
//   line, then a single-cycle done. count=0 gives done the cycle after go.
//   Ports: clk, reset (async, active-high), go, line, count[6:0] in;
//          done, resp, incp, resv, incv out (all registered).
// ----------------------------------------------------------------------------
module stonyman_pulse_gen
  import stonyman_pkg::*;
#(
  parameter int PULSE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  line_e      line,
  input  logic [6:0] count,
  output logic       done,
  output logic       resp,
  output logic       incp,
  output logic       resv,
  output logic       incv
);

  localparam int TW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [1:0] {PG_IDLE, PG_HIGH, PG_LOW} pg_state_e;

  pg_state_e   state_q;
  line_e       line_q;
  logic [6:0]  remain_q;
  logic [TW-1:0] timer_q;
  logic [3:0]  lines_q;   // one-hot {incv, resv, incp, resp}
  logic        done_q;

  // NOTE: sequential state is written with non-blocking assignments only so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PG_IDLE;
      line_q   <= LINE_RESP;
      remain_q <= '0;
      timer_q  <= '0;
      lines_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PG_IDLE: begin
          if (go) begin
            line_q   <= line;
            remain_q <= count;
            timer_q  <= TW'(PULSE_CYCLES - 1);
            if (count == 7'd0) begin
              done_q <= 1'b1;
            end else begin
              lines_q <= 4'b0001 << line;
              state_q <= PG_HIGH;
            end
          end
        end
        PG_HIGH: begin
          if (timer_q == '0) begin
            lines_q <= '0;
            timer_q <= TW'(PULSE_CYCLES - 1);
            state_q <= PG_LOW;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        PG_LOW: begin
          if (timer_q == '0) begin
            if (remain_q == 7'd1) begin
              done_q  <= 1'b1;
              state_q <= PG_IDLE;
            end else begin
              remain_q <= remain_q - 7'd1;
              lines_q  <= 4'b0001 << line_q;
              timer_q  <= TW'(PULSE_CYCLES - 1);
              state_q  <= PG_HIGH;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= PG_IDLE;
      endcase
    end
  end

  assign done = done_q;
  assign resp = lines_q[0];
  assign incp = lines_q[1];
  assign resv = lines_q[2];
  assign incv = lines_q[3];

endmodule

// File: rtl/stonyman_controller.sv
// ----------------------------------------------------------------------------
// stonyman_controller
//   Scans one full Stonyman frame per frame_start in row-major order: selects
//   each pixel through the sensor pointer/value lines, waits SETTLE_CYCLES,
//   pulses adc_capture_start and waits for adc_capture_done.
//   Ports: clk, reset (async, active-high), bus (stonyman_if.master);
//          with STONYMAN_CFG_EN: cfg_vref, cfg_config, cfg_nbias, cfg_aobias
//          [5:0], sampled at frame acceptance and written before row 0.
// ----------------------------------------------------------------------------
module stonyman_controller
  import stonyman_pkg::*;
#(
  parameter int ROWS          = 112,
  parameter int COLS          = 112,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
`ifdef STONYMAN_CFG_EN
  input  logic [5:0] cfg_vref,
  input  logic [5:0] cfg_config,
  input  logic [5:0] cfg_nbias,
  input  logic [5:0] cfg_aobias,
`endif
  stonyman_if.master bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  state_e        state_q;
  logic [3:0]    step_q;     // CFG: [3:2] register index, [1:0] WRITE phase
  logic          wait_q;     // request issued, waiting for pulse_gen done
  logic          go_q;
  pulse_req_t    req_q;
  logic [6:0]    row_q, col_q;
  logic [SW-1:0] timer_q;
  logic          start_q, busy_q, done_q;
`ifdef STONYMAN_CFG_EN
  logic [3:0][5:0] cfg_q;
`endif

  logic       pg_done, resp_w, incp_w, resv_w, incv_w;
  pulse_req_t step_req;
  logic [3:0] last_step;

  // Request for the current step of whichever line sequence is running.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    step_req  = write_step(step_q[1:0], ADDR_COLSEL, 7'd0);
    last_step = 4'd3;
    case (state_q)
      ST_ROW_SEL: step_req = write_step(step_q[1:0], ADDR_ROWSEL, row_q);
`ifdef STONYMAN_CFG_EN
      ST_CFG: begin
        step_req  = write_step(step_q[1:0], ADDR_VREF + 7'(step_q[3:2]),
                               {1'b0, cfg_q[step_q[3:2]]});
        last_step = 4'd15;
      end
`endif
      ST_COL_INC: begin
        step_req.line  = LINE_INCV;
        step_req.count = 7'd1;
        last_step      = 4'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      wait_q  <= 1'b0;
      go_q    <= 1'b0;
      req_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      timer_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STONYMAN_CFG_EN
      // NOTE: this small register file is reset like any other flop; a large
      // storage array would be left unreset to map onto RAM.
      cfg_q   <= '0;
`endif
    end else begin
      go_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) begin
            busy_q <= 1'b1;
            row_q  <= '0;
            col_q  <= '0;
            step_q <= '0;
            wait_q <= 1'b0;
`ifdef STONYMAN_CFG_EN
            cfg_q   <= {cfg_aobias, cfg_nbias, cfg_config, cfg_vref};
            state_q <= ST_CFG;
`else
            state_q <= ST_ROW_SEL;
`endif
          end
        end
        // Line sequences: issue one pulse_gen request, wait for its done.
        ST_CFG, ST_ROW_SEL, ST_COL_RST, ST_COL_INC: begin
          if (!wait_q) begin
            go_q   <= 1'b1;
            req_q  <= step_req;
            wait_q <= 1'b1;
          end else if (pg_done) begin
            wait_q <= 1'b0;
            if (step_q == last_step) begin
              step_q <= '0;
              if (state_q == ST_COL_INC) col_q <= col_q + 7'd1;
              case (state_q)
                ST_CFG:     state_q <= ST_ROW_SEL;
                ST_ROW_SEL: state_q <= ST_COL_RST;
                default: begin
                  timer_q <= SW'(SETTLE_CYCLES - 1);
                  state_q <= ST_SETTLE;
                end
              endcase
            end else begin
              step_q <= step_q + 4'd1;
            end
          end
        end
        ST_SETTLE: begin
          if (timer_q == '0) begin
            start_q <= 1'b1;
            state_q <= ST_CAPTURE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        // A done coincident with the start pulse is not looked at here.
        ST_CAPTURE: state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (bus.adc_capture_done) begin
            if (col_q != LAST_COL) begin
              step_q  <= '0;
              state_q <= ST_COL_INC;
            end else if (row_q != LAST_ROW) begin
              state_q <= ST_ROW_NEXT;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ROW_NEXT: begin
          row_q   <= row_q + 7'd1;
          col_q   <= '0;
          step_q  <= '0;
          state_q <= ST_ROW_SEL;
        end
        default: state_q <= ST_IDLE;  // ST_DONE: frame_start here is ignored
      endcase
    end
  end

  stonyman_pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_pulse_gen (
    .clk   (clk),
    .reset (reset),
    .go    (go_q),
    .line  (req_q.line),
    .count (req_q.count),
    .done  (pg_done),
    .resp  (resp_w),
    .incp  (incp_w),
    .resv  (resv_w),
    .incv  (incv_w)
  );

  assign bus.adc_capture_start = start_q;
  assign bus.frame_busy        = busy_q;
  assign bus.frame_done        = done_q;
  assign bus.pixel_row         = row_q;
  assign bus.pixel_col         = col_q;
  assign bus.resp              = resp_w;
  assign bus.incp              = incp_w;
  assign bus.resv              = resv_w;
  assign bus.incv              = incv_w;

endmodule

// File: tb/tb_stonyman_controller.sv
// ----------------------------------------------------------------------------
// tb_stonyman_controller
//   Drives frames into stonyman_controller (ROWS=2 COLS=3 PULSE_CYCLES=1
//   SETTLE_CYCLES=2), models the sensor register file from the line pulses
//   and the ADC controller, and compares against row-major expectations.
//   Build with STONYMAN_CFG_EN to cover the configuration writes.
// ----------------------------------------------------------------------------
module tb_stonyman_controller;

  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int NPIX = ROWS * COLS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stonyman_if bus ();

  stonyman_controller #(
    .ROWS(ROWS), .COLS(COLS), .PULSE_CYCLES(1), .SETTLE_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef STONYMAN_CFG_EN
    .cfg_vref   (6'd3),
    .cfg_config (6'd0),
    .cfg_nbias  (6'd0),
    .cfg_aobias (6'd0),
`endif
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Sensor model: pointer plus eight value registers, driven by rising edges.
  logic p_resp = 0, p_incp = 0, p_resv = 0, p_incv = 0;
  int   ptr = 0;
  int   sreg [8];
  int   trace [$];      // rising-edge order: 0 resp, 1 incp, 2 resv, 3 incv

  // ADC model and event bookkeeping.
  int n_start, n_done, toggles, overlap_viol, adc_viol;
  int adc_timer = 0;
  int stall_idx = -1;
  bit rand_delay, early_done, stall_active;
  int snap_toggles, snap_starts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update models, drive inputs.
  task automatic tick();
    @(negedge clk);
    bus.frame_start      = 1'b0;
    bus.adc_capture_done = 1'b0;
    if (bus.resp && !p_resp) begin ptr = 0;               trace.push_back(0); end
    if (bus.incp && !p_incp) begin ptr = (ptr + 1) % 8;   trace.push_back(1); end
    if (bus.resv && !p_resv) begin sreg[ptr] = 0;         trace.push_back(2); end
    if (bus.incv && !p_incv) begin sreg[ptr]++;           trace.push_back(3); end
    if ({bus.resp, bus.incp, bus.resv, bus.incv} != {p_resp, p_incp, p_resv, p_incv}) toggles++;
    if (int'(bus.resp) + int'(bus.incp) + int'(bus.resv) + int'(bus.incv) > 1) overlap_viol++;
    {p_resp, p_incp, p_resv, p_incv} = {bus.resp, bus.incp, bus.resv, bus.incv};

    if (adc_timer > 0) begin
      adc_timer--;
      if (adc_timer == 0) begin
        if (stall_active) begin
          check("stall_no_toggle", toggles, snap_toggles);
          check("stall_no_start", n_start, snap_starts);
          stall_active = 0;
        end
        bus.adc_capture_done = 1'b1;
      end
    end

    if (bus.adc_capture_start) begin
      if (adc_timer != 0) adc_viol++;
      check("cap_row", bus.pixel_row, n_start / COLS);
      check("cap_col", bus.pixel_col, n_start % COLS);
      check("sensor_rowsel", bus.pixel_row, sreg[1]);
      check("sensor_colsel", bus.pixel_col, sreg[0]);
      if (n_start == stall_idx) begin
        adc_timer    = 500;
        stall_active = 1;
        snap_toggles = toggles;
        snap_starts  = n_start + 1;
      end else begin
        adc_timer = rand_delay ? int'($urandom_range(1, 8)) : 5;
      end
      if (early_done) bus.adc_capture_done = 1'b1;  // same-cycle done, must be ignored
      n_start++;
    end

    if (bus.frame_done) begin
      n_done++;
      check("done_busy_low", bus.frame_busy, 0);
    end
  endtask

  // Whole-frame line edge sequence, derived from the WRITE rules.
  task automatic check_trace(input string tag);
    int exp [$];
    int bad;
`ifdef STONYMAN_CFG_EN
    for (int r = 0; r < 4; r++) begin
      exp.push_back(0);
      repeat (4 + r) exp.push_back(1);
      exp.push_back(2);
      if (r == 0) repeat (3) exp.push_back(3);
    end
`endif
    for (int r = 0; r < ROWS; r++) begin
      exp.push_back(0); exp.push_back(1); exp.push_back(2);
      repeat (r) exp.push_back(3);
      exp.push_back(0); exp.push_back(2);
      repeat (COLS - 1) exp.push_back(3);
    end
    check({tag, "_trace_len"}, trace.size(), exp.size());
    bad = 0;
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      if (trace[i] != exp[i]) bad++;
    check({tag, "_trace_order"}, bad, 0);
  endtask

  task automatic run_frame(input string tag, input int stall, input bit rnd,
                           input bit early, input int spur_a, input int spur_b,
                           input bit start_in_done);
    int c;
    n_start = 0; n_done = 0; adc_viol = 0; overlap_viol = 0;
    stall_idx = stall; rand_delay = rnd; early_done = early;
    trace.delete();
    bus.frame_start = 1'b1;
    tick();
    check({tag, "_busy_rise"}, bus.frame_busy, 1);
    check({tag, "_start_pix"}, {bus.pixel_row, bus.pixel_col}, 0);
    c = 1;
    while (n_done == 0 && c < 3000) begin
      if ((c == spur_a || c == spur_b) && bus.frame_busy) bus.frame_start = 1'b1;
      tick();
      c++;
    end
    check({tag, "_frame_done_seen"}, n_done, 1);
    if (start_in_done) bus.frame_start = 1'b1;
    repeat (40) tick();
    check({tag, "_captures"}, n_start, NPIX);
    check({tag, "_frame_dones"}, n_done, 1);
    check({tag, "_busy_after"}, bus.frame_busy, 0);
    check({tag, "_adc_protocol"}, adc_viol, 0);
    check({tag, "_one_line"}, overlap_viol, 0);
    check_trace(tag);
  endtask

  function automatic logic [22:0] all_outputs();
    return {bus.adc_capture_start, bus.frame_busy, bus.frame_done, bus.pixel_row,
            bus.pixel_col, bus.resp, bus.incp, bus.resv, bus.incv};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    foreach (sreg[i]) sreg[i] = 0;
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.adc_capture_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    reset = 1'b0;
    tick();
    check("idle_outputs", all_outputs(), 0);

    run_frame("basic", -1, 0, 0, -1, -1, 0);
    run_frame("spur", -1, 0, 0, 3, 40, 1);
    run_frame("stall", 1, 0, 0, -1, -1, 0);
    run_frame("rand", -1, 1, 1, int'($urandom_range(2, 30)), int'($urandom_range(31, 60)), 0);

    // Reset in the middle of a column-increment pulse.
    n_start = 0; stall_idx = -1; rand_delay = 0; early_done = 0;
    bus.frame_start = 1'b1;
    tick();
    c = 0;
    while (!(n_start >= 1 && bus.incv) && c < 2000) begin
      tick();
      c++;
    end
    check("rst_incv_found", bus.incv, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_pulse_outputs", all_outputs(), 0);
    @(negedge clk);
    check("rst_held_outputs", all_outputs(), 0);
    reset = 1'b0;
    adc_timer = 0;
    stall_active = 0;
    run_frame("post_rst", -1, 0, 0, -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
